log_entry_separator: RTL and testbench
======================================

Name: log_entry_separator

Overview:
- Stage directly downstream of the log-install header strip. It consumes the realigned log-entry stream that remains after the start-view header is removed.
- Splits each log entry into two writes: its header line goes to the header log, its payload lines go to the data log.
- Maintains the header-log and data-log tails, and reports first/last op numbers for the replica core once the install completes.

Parameters:
- NOC_DATA_W, 512, stream and data-log line width in bits (64 bytes).
- LOG_HDR_DEPTH_W, 8, log2 of header-log entry count.
- LOG_DATA_DEPTH_W, 12, log2 of data-log line count.
- INT_W, 32, op number / view number width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_sep  in  1  one-cycle pulse; begin a new install
- start_num_entries  in  INT_W  entry count, sampled with start_sep
- src_sep_data_val  in  1  stream valid
- src_sep_data  in  NOC_DATA_W  stream line
- src_sep_data_last  in  1  final line of stream
- src_sep_data_padbytes  in  NOC_PADBYTES_W  unused bytes in last line
- sep_src_data_rdy  out  1  stream ready
- hdr_log_wr_val  out  1  header-log write valid
- hdr_log_wr_addr  out  LOG_HDR_DEPTH_W  header-log slot
- hdr_log_wr_data  out  LOG_HDR_ENTRY_W  stored header entry
- hdr_log_wr_rdy  in  1  header-log ready
- data_log_wr_val  out  1  data-log write valid
- data_log_wr_addr  out  LOG_DATA_DEPTH_W  data-log line
- data_log_wr_data  out  NOC_DATA_W  payload line
- data_log_wr_rdy  in  1  data-log ready
- sep_done  out  1  one-cycle pulse; install complete
- sep_err  out  1  one-cycle pulse; stream/count mismatch
- first_log_op  out  INT_W  op number of first entry
- last_log_op  out  INT_W  op number of last entry
- hdr_log_tail  out  LOG_HDR_DEPTH_W+1  header-log tail; MSB is wrap bit
- data_log_tail  out  LOG_DATA_DEPTH_W+1  data-log tail; MSB is wrap bit

Behaviour:
- Reset: state SEP_IDLE, all registers 0.
  - Outputs at reset: val/rdy/done/err all 0; tails 0; first_log_op and last_log_op 0.
- Entry format, line-aligned:
  - Line 0 carries log_entry_hdr in its MSBs: view INT_W, op_num INT_W, data_len 16 bits (bytes).
  - Followed by ceil(data_len/64) payload lines.
  - Next entry begins on a fresh line.
- Header-log entry = {log_entry_hdr, data_ptr}, where data_ptr = data_log_tail at the entry's first payload line.
- SEP_IDLE:
  - sep_src_data_rdy = 0.
  - On start_sep: clear both tails, latch entries_left = start_num_entries.
  - If count == 0: go to SEP_DONE. Otherwise go to SEP_HDR.
- SEP_HDR:
  - hdr_log_wr_val = src val; sep_src_data_rdy = hdr_log_wr_rdy.
  - Write address = hdr_log_tail[LOG_HDR_DEPTH_W-1:0].
  - On handshake:
    - hdr tail += 1.
    - Load lines_left = (data_len+63)>>6.
    - Record last_log_op = op_num.
    - Record first_log_op on the first entry only.
    - Decrement entries_left.
  - Next state:
    - lines_left == 0 and entries_left now 0: SEP_DONE.
    - lines_left == 0 otherwise: stay in SEP_HDR.
    - lines_left != 0: SEP_DATA.
- SEP_DATA:
  - data_log_wr_val = src val; sep_src_data_rdy = data_log_wr_rdy.
  - Write address = data tail low bits.
  - On handshake: data tail += 1, lines_left -= 1.
  - When lines_left reaches 0: SEP_DONE if entries_left == 0, else SEP_HDR.
- SEP_DONE: pulse sep_done for one cycle, then return to SEP_IDLE.
- Throughput and latency:
  - One line per cycle at full throughput.
  - Write outputs are a combinational pass-through: zero cycles from stream line to write request.
  - Data and address must be held stable while val && !rdy.
- Tails are modulo 2^(DEPTH_W+1); wrap is silent. The install overwrites the log, so there is no full check.
- Errors:
  - src last accepted while entries_left or lines_left is still nonzero (before the final line): pulse sep_err, return to SEP_IDLE, tails keep their partial values.
  - Final line accepted without src last: sep_err pulses with sep_done.
- start_sep outside SEP_IDLE is ignored.
- rst_n assertion mid-install aborts immediately to reset values.

Decomposition:
- Shared package holds:
  - log_entry_hdr struct and LOG_ENTRY_HDR_W.
  - log_hdr_entry struct (hdr + data_ptr) and LOG_HDR_ENTRY_W.
  - sep_state enum: SEP_IDLE, SEP_HDR, SEP_DATA, SEP_DONE.
  - LINE_BYTES = 64.
- Single module, no sub-module. The ceil-divide is inline.

Test Plan:
- start_num_entries=0 -> sep_done one cycle after start, no writes, tails 0.
- 2 entries (op 5, len 100; op 6, len 64):
  - hdr writes at addr 0,1.
  - data writes at 0,1,2 with data_ptrs 0 and 2.
  - Final state: first=5, last=6, hdr_tail=2, data_tail=3, sep_done.
- Entry with len 0 followed by entry with len 1 -> data_ptrs 0 and 0, data_tail=1.
- Random rdy deassertion on both logs -> same write sequence, no dropped or duplicated lines, data stable while stalled.
- 300 entries of len 0 with LOG_HDR_DEPTH_W=8 -> hdr_log_tail=9'd300-256 with MSB set (=0x12C), addresses wrap to 0.
- num_entries=3 but src last on 2nd entry's header -> sep_err pulse, no sep_done, state SEP_IDLE.
- rst_n low mid-SEP_DATA -> all outputs to 0 asynchronously.

Source files
------------

// File: rtl/log_entry_separator_pkg.sv
// Shared types for the log-entry separator: the on-stream entry header, the stored
// header-log entry, and the separator state encoding.
package log_entry_separator_pkg;

  localparam int NOC_DATA_W       = 512;
  localparam int LOG_HDR_DEPTH_W  = 8;
  localparam int LOG_DATA_DEPTH_W = 12;
  localparam int INT_W            = 32;
  localparam int LINE_BYTES       = 64;
  localparam int LINE_SHIFT       = $clog2(LINE_BYTES);
  localparam int NOC_PADBYTES_W   = $clog2(LINE_BYTES);
  localparam int DATA_LEN_W       = 16;
  // Enough bits for ceil(0xFFFF / 64) = 1024.
  localparam int LINES_W          = DATA_LEN_W - LINE_SHIFT + 1;

  typedef struct packed {
    logic [INT_W-1:0]      view;
    logic [INT_W-1:0]      op_num;
    logic [DATA_LEN_W-1:0] data_len;
  } log_entry_hdr_t;

  localparam int LOG_ENTRY_HDR_W = $bits(log_entry_hdr_t);

  typedef struct packed {
    log_entry_hdr_t            hdr;
    logic [LOG_DATA_DEPTH_W:0] data_ptr;
  } log_hdr_entry_t;

  localparam int LOG_HDR_ENTRY_W = $bits(log_hdr_entry_t);

  typedef enum logic [1:0] {
    SEP_IDLE = 2'd0,
    SEP_HDR  = 2'd1,
    SEP_DATA = 2'd2,
    SEP_DONE = 2'd3
  } sep_state_e;

endpackage

// File: rtl/log_entry_separator.sv
// Splits the realigned log-install stream into header-log and data-log writes,
// tracking both log tails and the first/last op numbers of the install.
module log_entry_separator
  import log_entry_separator_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic                        start_sep,
  input  logic [INT_W-1:0]            start_num_entries,

  input  logic                        src_sep_data_val,
  input  logic [NOC_DATA_W-1:0]       src_sep_data,
  input  logic                        src_sep_data_last,
  input  logic [NOC_PADBYTES_W-1:0]   src_sep_data_padbytes,
  output logic                        sep_src_data_rdy,

  output logic                        hdr_log_wr_val,
  output logic [LOG_HDR_DEPTH_W-1:0]  hdr_log_wr_addr,
  output logic [LOG_HDR_ENTRY_W-1:0]  hdr_log_wr_data,
  input  logic                        hdr_log_wr_rdy,

  output logic                        data_log_wr_val,
  output logic [LOG_DATA_DEPTH_W-1:0] data_log_wr_addr,
  output logic [NOC_DATA_W-1:0]       data_log_wr_data,
  input  logic                        data_log_wr_rdy,

  output logic                        sep_done,
  output logic                        sep_err,
  output logic [INT_W-1:0]            first_log_op,
  output logic [INT_W-1:0]            last_log_op,
  output logic [LOG_HDR_DEPTH_W:0]    hdr_log_tail,
  output logic [LOG_DATA_DEPTH_W:0]   data_log_tail
);

  sep_state_e           state, state_nxt;
  logic [INT_W-1:0]     entries_left;
  logic [LINES_W-1:0]   lines_left;
  logic                 first_seen;
  logic                 err_q, err_nxt;

  log_entry_hdr_t       line_hdr;
  log_hdr_entry_t       hdr_entry;
  logic [DATA_LEN_W:0]  len_sum;
  logic [LINES_W-1:0]   lines_new;
  logic [INT_W-1:0]     entries_dec;
  logic                 hdr_hs, data_hs;
  logic                 hdr_final, data_final;

  // Padding is only meaningful to the upstream realigner; lines are consumed whole.
  logic unused_padbytes;
  assign unused_padbytes = ^src_sep_data_padbytes;

  assign line_hdr    = log_entry_hdr_t'(src_sep_data[NOC_DATA_W-1 -: LOG_ENTRY_HDR_W]);
  assign len_sum     = {1'b0, line_hdr.data_len} + (DATA_LEN_W+1)'(LINE_BYTES-1);
  assign lines_new   = len_sum[DATA_LEN_W:LINE_SHIFT];
  assign entries_dec = entries_left - INT_W'(1);

  assign hdr_hs     = (state == SEP_HDR)  && src_sep_data_val && hdr_log_wr_rdy;
  assign data_hs    = (state == SEP_DATA) && src_sep_data_val && data_log_wr_rdy;
  assign hdr_final  = (lines_new == '0) && (entries_dec == '0);
  assign data_final = (lines_left == LINES_W'(1)) && (entries_left == '0);

  assign hdr_entry.hdr      = line_hdr;
  assign hdr_entry.data_ptr = data_log_tail;

  assign hdr_log_wr_addr  = hdr_log_tail[LOG_HDR_DEPTH_W-1:0];
  assign data_log_wr_addr = data_log_tail[LOG_DATA_DEPTH_W-1:0];
  assign sep_done         = (state == SEP_DONE);
  assign sep_err          = err_q;

  always_comb begin
    state_nxt        = state;
    err_nxt          = 1'b0;
    sep_src_data_rdy = 1'b0;
    hdr_log_wr_val   = 1'b0;
    hdr_log_wr_data  = '0;
    data_log_wr_val  = 1'b0;
    data_log_wr_data = '0;
    case (state)
      SEP_IDLE: begin
        if (start_sep) state_nxt = (start_num_entries == '0) ? SEP_DONE : SEP_HDR;
      end
      SEP_HDR: begin
        hdr_log_wr_val   = src_sep_data_val;
        sep_src_data_rdy = hdr_log_wr_rdy;
        hdr_log_wr_data  = hdr_entry;
        if (hdr_hs) begin
          if (src_sep_data_last && !hdr_final) begin
            state_nxt = SEP_IDLE;
            err_nxt   = 1'b1;
          end else if (lines_new != '0) begin
            state_nxt = SEP_DATA;
          end else if (entries_dec == '0) begin
            state_nxt = SEP_DONE;
            err_nxt   = !src_sep_data_last;
          end
        end
      end
      SEP_DATA: begin
        data_log_wr_val  = src_sep_data_val;
        sep_src_data_rdy = data_log_wr_rdy;
        data_log_wr_data = src_sep_data;
        if (data_hs) begin
          if (src_sep_data_last && !data_final) begin
            state_nxt = SEP_IDLE;
            err_nxt   = 1'b1;
          end else if (lines_left == LINES_W'(1)) begin
            if (entries_left == '0) begin
              state_nxt = SEP_DONE;
              err_nxt   = !src_sep_data_last;
            end else begin
              state_nxt = SEP_HDR;
            end
          end
        end
      end
      SEP_DONE: state_nxt = SEP_IDLE;
      default:  state_nxt = SEP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= SEP_IDLE;
      err_q         <= 1'b0;
      entries_left  <= '0;
      lines_left    <= '0;
      first_seen    <= 1'b0;
      first_log_op  <= '0;
      last_log_op   <= '0;
      hdr_log_tail  <= '0;
      data_log_tail <= '0;
    end else begin
      state <= state_nxt;
      err_q <= err_nxt;
      if (state == SEP_IDLE && start_sep) begin
        entries_left  <= start_num_entries;
        lines_left    <= '0;
        first_seen    <= 1'b0;
        first_log_op  <= '0;
        last_log_op   <= '0;
        hdr_log_tail  <= '0;
        data_log_tail <= '0;
      end
      if (hdr_hs) begin
        hdr_log_tail <= hdr_log_tail + 1'b1;
        lines_left   <= lines_new;
        entries_left <= entries_dec;
        last_log_op  <= line_hdr.op_num;
        if (!first_seen) begin
          first_log_op <= line_hdr.op_num;
          first_seen   <= 1'b1;
        end
      end
      if (data_hs) begin
        data_log_tail <= data_log_tail + 1'b1;
        lines_left    <= lines_left - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_log_entry_separator.sv
// Directed bench for log_entry_separator: drives entry streams and compares the
// header-log and data-log writes against a reference built from the entry list.
module tb_log_entry_separator;
  import log_entry_separator_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                        start_sep = 1'b0;
  logic [INT_W-1:0]            start_num_entries = '0;
  logic                        src_sep_data_val = 1'b0;
  logic [NOC_DATA_W-1:0]       src_sep_data = '0;
  logic                        src_sep_data_last = 1'b0;
  logic [NOC_PADBYTES_W-1:0]   src_sep_data_padbytes = '0;
  logic                        sep_src_data_rdy;
  logic                        hdr_log_wr_val;
  logic [LOG_HDR_DEPTH_W-1:0]  hdr_log_wr_addr;
  logic [LOG_HDR_ENTRY_W-1:0]  hdr_log_wr_data;
  logic                        hdr_log_wr_rdy = 1'b1;
  logic                        data_log_wr_val;
  logic [LOG_DATA_DEPTH_W-1:0] data_log_wr_addr;
  logic [NOC_DATA_W-1:0]       data_log_wr_data;
  logic                        data_log_wr_rdy = 1'b1;
  logic                        sep_done, sep_err;
  logic [INT_W-1:0]            first_log_op, last_log_op;
  logic [LOG_HDR_DEPTH_W:0]    hdr_log_tail;
  logic [LOG_DATA_DEPTH_W:0]   data_log_tail;

  log_entry_separator dut (
    .clk(clk), .rst_n(rst_n),
    .start_sep(start_sep), .start_num_entries(start_num_entries),
    .src_sep_data_val(src_sep_data_val), .src_sep_data(src_sep_data),
    .src_sep_data_last(src_sep_data_last), .src_sep_data_padbytes(src_sep_data_padbytes),
    .sep_src_data_rdy(sep_src_data_rdy),
    .hdr_log_wr_val(hdr_log_wr_val), .hdr_log_wr_addr(hdr_log_wr_addr),
    .hdr_log_wr_data(hdr_log_wr_data), .hdr_log_wr_rdy(hdr_log_wr_rdy),
    .data_log_wr_val(data_log_wr_val), .data_log_wr_addr(data_log_wr_addr),
    .data_log_wr_data(data_log_wr_data), .data_log_wr_rdy(data_log_wr_rdy),
    .sep_done(sep_done), .sep_err(sep_err),
    .first_log_op(first_log_op), .last_log_op(last_log_op),
    .hdr_log_tail(hdr_log_tail), .data_log_tail(data_log_tail)
  );

  int errors = 0;
  int checks = 0;

  logic [LOG_HDR_DEPTH_W-1:0]  act_haddr[$], exp_haddr[$];
  logic [LOG_HDR_ENTRY_W-1:0]  act_hdata[$], exp_hdata[$];
  logic [LOG_DATA_DEPTH_W-1:0] act_daddr[$], exp_daddr[$];
  logic [NOC_DATA_W-1:0]       act_ddata[$], exp_ddata[$];
  int e_op[$], e_len[$];
  int done_cnt, err_cnt, both_cnt, stall_cnt, stall_viol;
  bit rand_rdy = 1'b0;

  logic                        h_stall_q = 1'b0, d_stall_q = 1'b0;
  logic [LOG_HDR_DEPTH_W-1:0]  h_addr_q;
  logic [LOG_HDR_ENTRY_W-1:0]  h_data_q;
  logic [LOG_DATA_DEPTH_W-1:0] d_addr_q;
  logic [NOC_DATA_W-1:0]       d_data_q;

  // Write/pulse recorder, sampled mid-cycle while inputs and outputs are settled.
  always @(negedge clk) begin
    if (h_stall_q && (hdr_log_wr_addr !== h_addr_q || hdr_log_wr_data !== h_data_q)) stall_viol++;
    if (d_stall_q && (data_log_wr_addr !== d_addr_q || data_log_wr_data !== d_data_q)) stall_viol++;
    h_stall_q = hdr_log_wr_val && !hdr_log_wr_rdy;
    d_stall_q = data_log_wr_val && !data_log_wr_rdy;
    if (h_stall_q || d_stall_q) stall_cnt++;
    h_addr_q = hdr_log_wr_addr;  h_data_q = hdr_log_wr_data;
    d_addr_q = data_log_wr_addr; d_data_q = data_log_wr_data;
    if (hdr_log_wr_val && hdr_log_wr_rdy) begin
      act_haddr.push_back(hdr_log_wr_addr);
      act_hdata.push_back(hdr_log_wr_data);
    end
    if (data_log_wr_val && data_log_wr_rdy) begin
      act_daddr.push_back(data_log_wr_addr);
      act_ddata.push_back(data_log_wr_data);
    end
    if (sep_done) done_cnt++;
    if (sep_err) err_cnt++;
    if (sep_done && sep_err) both_cnt++;
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) begin
      hdr_log_wr_rdy  = 1'($urandom_range(0, 1));
      data_log_wr_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  function automatic logic [NOC_DATA_W-1:0] hdr_line(input int view, input int op, input int len);
    return {32'(view), 32'(op), 16'(len), {27{16'hBEEF}}};
  endfunction

  function automatic logic [NOC_DATA_W-1:0] pay_line(input int i, input int k);
    return {16{32'hC0DE_0000 ^ 32'(i * 256 + k)}};
  endfunction

  function automatic int count_diffs();
    int d = 0;
    if (act_haddr.size() != exp_haddr.size()) d++;
    if (act_daddr.size() != exp_daddr.size()) d++;
    foreach (exp_haddr[i])
      if (i < act_haddr.size() && (act_haddr[i] !== exp_haddr[i] || act_hdata[i] !== exp_hdata[i])) d++;
    foreach (exp_daddr[i])
      if (i < act_daddr.size() && (act_daddr[i] !== exp_daddr[i] || act_ddata[i] !== exp_ddata[i])) d++;
    return d;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the line is accepted.
  task automatic send_line(input logic [NOC_DATA_W-1:0] d, input logic last);
    int  n = 0;
    logic hs = 1'b0;
    src_sep_data_val = 1'b1; src_sep_data = d; src_sep_data_last = last;
    while (!hs && n < 200) begin
      @(negedge clk); hs = sep_src_data_rdy;
      @(posedge clk); #1; n++;
    end
    src_sep_data_val = 1'b0; src_sep_data_last = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL send_line: line not accepted after %0d cycles, want accept", n);
    end
  endtask

  task automatic clear_run();
    act_haddr.delete(); act_hdata.delete(); act_daddr.delete(); act_ddata.delete();
    exp_haddr.delete(); exp_hdata.delete(); exp_daddr.delete(); exp_ddata.delete();
    done_cnt = 0; err_cnt = 0; both_cnt = 0; stall_cnt = 0; stall_viol = 0;
  endtask

  task automatic pulse_start(input int n);
    start_num_entries = 32'(n); start_sep = 1'b1;
    @(posedge clk); #1;
    start_sep = 1'b0;
  endtask

  task automatic run_install(input bit drop_last);
    int n = e_op.size();
    int dptr = 0;
    clear_run();
    pulse_start(n);
    for (int i = 0; i < n; i++) begin
      int nl = (e_len[i] + 63) / 64;
      bit fin = (i == n - 1) && !drop_last;
      exp_haddr.push_back(8'(i));
      exp_hdata.push_back({32'(7 + i), 32'(e_op[i]), 16'(e_len[i]), 13'(dptr)});
      send_line(hdr_line(7 + i, e_op[i], e_len[i]), fin && nl == 0);
      for (int k = 0; k < nl; k++) begin
        exp_daddr.push_back(12'(dptr));
        exp_ddata.push_back(pay_line(i, k));
        send_line(pay_line(i, k), fin && k == nl - 1);
        dptr++;
      end
    end
    for (int w = 0; w < 50 && done_cnt == 0 && err_cnt == 0; w++) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (sep_src_data_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", sep_src_data_rdy); end
    checks++; if ({hdr_log_wr_val, data_log_wr_val, sep_done, sep_err} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {hdr_log_wr_val, data_log_wr_val, sep_done, sep_err}); end
    checks++; if ({hdr_log_tail, data_log_tail} !== '0) begin errors++; $display("FAIL reset_tails: got %h/%h want 0/0", hdr_log_tail, data_log_tail); end
    checks++; if ({first_log_op, last_log_op} !== 64'h0) begin errors++; $display("FAIL reset_ops: got %0d/%0d want 0/0", first_log_op, last_log_op); end
  endtask

  task automatic test_zero_entries();
    clear_run();
    pulse_start(0);
    @(negedge clk);
    checks++; if (sep_done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b want 1", sep_done); end
    @(posedge clk); #1; @(negedge clk);
    checks++; if (sep_done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %b want 0", sep_done); end
    checks++; if (act_haddr.size() + act_daddr.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", act_haddr.size() + act_daddr.size()); end
    checks++; if ({hdr_log_tail, data_log_tail} !== '0) begin errors++; $display("FAIL zero_tails: got %h/%h want 0/0", hdr_log_tail, data_log_tail); end
    @(posedge clk); #1;
  endtask

  task automatic test_two_entries();
    logic [12:0] ptr1;
    e_op = '{5, 6}; e_len = '{100, 64};
    run_install(1'b0);
    ptr1 = (act_hdata.size() > 1) ? act_hdata[1][12:0] : 13'h1FFF;
    checks++; if (count_diffs() != 0) begin errors++; $display("FAIL two_writes: got %0d diffs want 0", count_diffs()); end
    checks++; if (act_daddr.size() != 3) begin errors++; $display("FAIL two_data_cnt: got %0d want 3", act_daddr.size()); end
    checks++; if (ptr1 !== 13'd2) begin errors++; $display("FAIL two_ptr1: got %0d want 2", ptr1); end
    checks++; if (first_log_op !== 32'd5 || last_log_op !== 32'd6) begin errors++; $display("FAIL two_ops: got %0d/%0d want 5/6", first_log_op, last_log_op); end
    checks++; if (hdr_log_tail !== 9'd2 || data_log_tail !== 13'd3) begin errors++; $display("FAIL two_tails: got %0d/%0d want 2/3", hdr_log_tail, data_log_tail); end
    checks++; if (done_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL two_done: got done=%0d err=%0d want 1/0", done_cnt, err_cnt); end
  endtask

  task automatic test_zero_len();
    logic [12:0] ptr0, ptr1;
    e_op = '{20, 21}; e_len = '{0, 1};
    run_install(1'b0);
    ptr0 = (act_hdata.size() > 0) ? act_hdata[0][12:0] : 13'h1FFF;
    ptr1 = (act_hdata.size() > 1) ? act_hdata[1][12:0] : 13'h1FFF;
    checks++; if (count_diffs() != 0) begin errors++; $display("FAIL zlen_writes: got %0d diffs want 0", count_diffs()); end
    checks++; if (ptr0 !== 13'd0 || ptr1 !== 13'd0) begin errors++; $display("FAIL zlen_ptrs: got %0d/%0d want 0/0", ptr0, ptr1); end
    checks++; if (data_log_tail !== 13'd1) begin errors++; $display("FAIL zlen_tail: got %0d want 1", data_log_tail); end
    run_install(1'b1);
    checks++; if (both_cnt != 1 || err_cnt != 1) begin errors++; $display("FAIL nolast_err: got both=%0d err=%0d want 1/1", both_cnt, err_cnt); end
  endtask

  task automatic test_stall();
    e_op = '{10, 11, 12, 13}; e_len = '{130, 0, 64, 200};
    rand_rdy = 1'b1;
    run_install(1'b0);
    rand_rdy = 1'b0;
    hdr_log_wr_rdy = 1'b1; data_log_wr_rdy = 1'b1;
    checks++; if (count_diffs() != 0) begin errors++; $display("FAIL stall_writes: got %0d diffs want 0", count_diffs()); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_stable: got %0d changes want 0", stall_viol); end
    checks++; if (stall_cnt == 0) begin errors++; $display("FAIL stall_seen: got %0d stalls want >0", stall_cnt); end
    checks++; if (hdr_log_tail !== 9'd4 || data_log_tail !== 13'd8) begin errors++; $display("FAIL stall_tails: got %0d/%0d want 4/8", hdr_log_tail, data_log_tail); end
    checks++; if (done_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL stall_done: got done=%0d err=%0d want 1/0", done_cnt, err_cnt); end
  endtask

  task automatic test_wrap();
    logic [7:0] a256;
    e_op.delete(); e_len.delete();
    for (int i = 0; i < 300; i++) begin e_op.push_back(1000 + i); e_len.push_back(0); end
    run_install(1'b0);
    a256 = (act_haddr.size() > 256) ? act_haddr[256] : 8'hFF;
    checks++; if (hdr_log_tail !== 9'h12C) begin errors++; $display("FAIL wrap_tail: got %h want 12c", hdr_log_tail); end
    checks++; if (a256 !== 8'd0) begin errors++; $display("FAIL wrap_addr: got %0d want 0", a256); end
    checks++; if (count_diffs() != 0) begin errors++; $display("FAIL wrap_writes: got %0d diffs want 0", count_diffs()); end
    checks++; if (first_log_op !== 32'd1000 || last_log_op !== 32'd1299) begin errors++; $display("FAIL wrap_ops: got %0d/%0d want 1000/1299", first_log_op, last_log_op); end
  endtask

  task automatic test_early_last();
    clear_run();
    pulse_start(3);
    send_line(hdr_line(1, 40, 0), 1'b0);
    send_line(hdr_line(2, 41, 0), 1'b1);
    src_sep_data_val = 1'b1;
    @(negedge clk);
    checks++; if (sep_src_data_rdy !== 1'b0) begin errors++; $display("FAIL early_idle: got rdy=%b want 0", sep_src_data_rdy); end
    @(posedge clk); #1; src_sep_data_val = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    checks++; if (err_cnt != 1 || done_cnt != 0) begin errors++; $display("FAIL early_err: got err=%0d done=%0d want 1/0", err_cnt, done_cnt); end
    checks++; if (hdr_log_tail !== 9'd2) begin errors++; $display("FAIL early_tail: got %0d want 2", hdr_log_tail); end
  endtask

  task automatic test_reset_mid_data();
    clear_run();
    pulse_start(1);
    send_line(hdr_line(9, 77, 640), 1'b0);
    for (int k = 0; k < 3; k++) send_line(pay_line(0, k), 1'b0);
    src_sep_data_val = 1'b1; src_sep_data = pay_line(0, 3);
    @(negedge clk);
    checks++; if (data_log_wr_val !== 1'b1) begin errors++; $display("FAIL mid_active: got %b want 1", data_log_wr_val); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({data_log_wr_val, sep_src_data_rdy} !== 2'b00 || data_log_wr_data !== '0) begin errors++; $display("FAIL mid_rst_out: got val=%b rdy=%b want 0/0 and zero data", data_log_wr_val, sep_src_data_rdy); end
    checks++; if ({hdr_log_tail, data_log_tail} !== '0 || last_log_op !== 32'd0) begin errors++; $display("FAIL mid_rst_regs: got %0d/%0d op=%0d want 0/0 op=0", hdr_log_tail, data_log_tail, last_log_op); end
    src_sep_data_val = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    test_zero_entries();
    test_two_entries();
    test_zero_len();
    test_stall();
    test_wrap();
    test_early_last();
    test_reset_mid_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
